// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
// Holds the default line count, the FSM state encoding and helpers that
// derive index/tag widths from a line count. Imported by every icache file.
package icache_pkg;

  localparam int unsigned ICACHE_LINES = 64;

  // FSM encoding
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLookup = 3'd1;
  localparam logic [2:0] StReq    = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StDrop   = 3'd4;

  // Index selects pc[idx_width+1:2]; tag is everything above it.
  function automatic int unsigned idx_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned lines);
    return 30 - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Memory-controller handshake between the icache and memctrl.
// Signals:
//   icache_in          cache -> memctrl  fill request (held until received)
//   icache_address_in  cache -> memctrl  word-aligned fill address
//   icache_received    memctrl -> cache  request accepted
//   icache_task_out    memctrl -> cache  value_load carries the icache fill
//   value_load         memctrl -> cache  load data (shared with the LSU)
// Modports: master = cache side, slave = memctrl side.
interface icache_if;
  logic        icache_in;
  logic [31:0] icache_address_in;
  logic        icache_received;
  logic        icache_task_out;
  logic [31:0] value_load;

  modport master (
    output icache_in,
    output icache_address_in,
    input  icache_received,
    input  icache_task_out,
    input  value_load
  );

  modport slave (
    input  icache_in,
    input  icache_address_in,
    output icache_received,
    output icache_task_out,
    output value_load
  );
endinterface

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: per-line valid bit, tag and one 32-bit word.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset (clears valid only)
//   rd_idx_i                 combinational read index
//   rd_valid_o/tag_o/data_o  contents of the indexed line
//   wr_en_i/idx_i/tag_i/data_i  single write port, sets the line valid
module icache_line_array #(
  parameter int unsigned Lines = 64,
  parameter int unsigned IdxW  = 6,
  parameter int unsigned TagW  = 24
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic            rd_valid_o,
  output logic [TagW-1:0] rd_tag_o,
  output logic [31:0]     rd_data_o,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [TagW-1:0] wr_tag_i,
  input  logic [31:0]     wr_data_i
);

  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [31:0]      data_q [Lines];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Fetch side: fetch_in/fetch_pc_in accepted while ready_out; a result appears
// as a one-cycle inst_valid_out pulse with inst_out/inst_pc_out. flush_in
// abandons the outstanding fetch (a fill already requested still completes).
// Memory side: mem_if (master modport of icache_if).
// rdy_in low freezes every register, including the valid array.
// Optional: define ICACHE_STATS_EN to add hit_cnt_out/miss_cnt_out counters.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = ICACHE_LINES
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        fetch_in,
  input  logic [31:0] fetch_pc_in,
  input  logic        flush_in,
  output logic        ready_out,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_cnt_out,
  output logic [31:0] miss_cnt_out,
`endif
  icache_if.master    mem_if
);

  localparam int unsigned IdxW = idx_width(LINES);
  localparam int unsigned TagW = tag_width(LINES);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic            line_valid;
  logic [TagW-1:0] line_tag;
  logic [31:0]     line_data;
  logic            hit;
  logic            fill_we;

  icache_line_array #(
    .Lines (LINES),
    .IdxW  (IdxW),
    .TagW  (TagW)
  ) u_lines (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .rd_idx_i   (pc_q[IdxW+1:2]),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (fill_we),
    .wr_idx_i   (pc_q[IdxW+1:2]),
    .wr_tag_i   (pc_q[31:IdxW+2]),
    .wr_data_i  (mem_if.value_load)
  );

  assign hit = line_valid && (line_tag == pc_q[31:IdxW+2]);

  // A fill lands in WAIT, or in DROP once the request has been accepted.
  assign fill_we = rdy_in && mem_if.icache_task_out &&
                   ((state_q == StWait) || ((state_q == StDrop) && !req_q));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if (rdy_in) begin
      valid_d = 1'b0;
      case (state_q)
        StIdle: begin
          if (fetch_in && !flush_in) begin
            pc_d    = fetch_pc_in;
            state_d = StLookup;
          end
        end
        StLookup: begin
          if (flush_in) begin
            state_d = StIdle;
          end else if (hit) begin
            valid_d   = 1'b1;
            inst_d    = line_data;
            inst_pc_d = pc_q;
            state_d   = StIdle;
          end else begin
            req_d   = 1'b1;
            addr_d  = {pc_q[31:2], 2'b00};
            state_d = StReq;
          end
        end
        StReq: begin
          if (mem_if.icache_received) begin
            req_d   = 1'b0;
            state_d = flush_in ? StDrop : StWait;
          end else if (flush_in) begin
            state_d = StDrop;
          end
        end
        StWait: begin
          if (mem_if.icache_task_out) begin
            state_d = StIdle;
            if (!flush_in) begin
              valid_d   = 1'b1;
              inst_d    = mem_if.value_load;
              inst_pc_d = pc_q;
            end
          end else if (flush_in) begin
            state_d = StDrop;
          end
        end
        StDrop: begin
          // Further flushes are ignored here; just finish the fill quietly.
          if (req_q) begin
            if (mem_if.icache_received) req_d = 1'b0;
          end else if (mem_if.icache_task_out) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign ready_out                = (state_q == StIdle);
  assign inst_valid_out           = valid_q;
  assign inst_out                 = inst_q;
  assign inst_pc_out              = inst_pc_q;
  assign mem_if.icache_in         = req_q;
  assign mem_if.icache_address_in = addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Counts every unflushed LOOKUP; wraps naturally at 2^32.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy_in && (state_q == StLookup) && !flush_in) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_out  = hit_cnt_q;
  assign miss_cnt_out = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (LINES=64). The bench plays the
// memory controller; expected {inst, pc} pairs are queued when a fetch is
// issued and popped when inst_valid_out pulses.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        fetch = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        flush = 1'b0;
  logic        ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_if mem_if ();

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  icache #(
    .LINES (64)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .fetch_in       (fetch),
    .fetch_pc_in    (fetch_pc),
    .flush_in       (flush),
    .ready_out      (ready),
    .inst_valid_out (inst_valid),
    .inst_out       (inst),
    .inst_pc_out    (inst_pc),
`ifdef ICACHE_STATS_EN
    .hit_cnt_out    (hit_cnt),
    .miss_cnt_out   (miss_cnt),
`endif
    .mem_if         (mem_if.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_output(input string tag);
    logic [63:0] e;
    check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s_sb: observed empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_inst"}, inst, e[63:32]);
      check({tag, "_pc"}, inst_pc, e[31:0]);
    end
  endtask

  // Presents a fetch for one cycle; returns with the DUT in LOOKUP.
  task automatic start_fetch(input logic [31:0] pc);
    fetch    = 1'b1;
    fetch_pc = pc;
    tick();
    fetch = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] pc, input logic [31:0] word, input string tag);
    sb.push_back({word, pc});
    start_fetch(pc);
    check({tag, "_busy"}, {31'd0, ready}, 32'd0);
    tick();
    check({tag, "_noreq"}, {31'd0, mem_if.icache_in}, 32'd0);
    expect_output(tag);
    tick();
    check({tag, "_pulse_end"}, {31'd0, inst_valid}, 32'd0);
  endtask

  task automatic do_miss(input logic [31:0] pc, input logic [31:0] word, input string tag);
    logic [31:0] aligned;
    aligned = {pc[31:2], 2'b00};
    sb.push_back({word, pc});
    start_fetch(pc);
    tick();
    check({tag, "_req"}, {31'd0, mem_if.icache_in}, 32'd1);
    check({tag, "_addr"}, mem_if.icache_address_in, aligned);
    for (int i = 0; i < 2; i++) begin
      tick();
      check({tag, "_req_hold"}, {31'd0, mem_if.icache_in}, 32'd1);
      check({tag, "_addr_hold"}, mem_if.icache_address_in, aligned);
    end
    mem_if.icache_received = 1'b1;
    tick();
    mem_if.icache_received = 1'b0;
    check({tag, "_req_drop"}, {31'd0, mem_if.icache_in}, 32'd0);
    // LSU traffic on the shared bus must be ignored.
    mem_if.value_load      = 32'hDEADBEEF;
    mem_if.icache_task_out = 1'b0;
    tick();
    check({tag, "_lsu_ignored"}, {31'd0, inst_valid}, 32'd0);
    mem_if.value_load      = word;
    mem_if.icache_task_out = 1'b1;
    tick();
    mem_if.icache_task_out = 1'b0;
    mem_if.value_load      = '0;
    expect_output(tag);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    tick();
    check({tag, "_pulse_end"}, {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_if.icache_received = 1'b0;
    mem_if.icache_task_out = 1'b0;
    mem_if.value_load      = '0;

    // Reset state
    #1;
    repeat (2) tick();
    check("rst_icache_in", {31'd0, mem_if.icache_in}, 32'd0);
    check("rst_addr", mem_if.icache_address_in, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", {31'd0, ready}, 32'd1);

    // Cold miss then hit on the same PC
    do_miss(32'h0000_1004, 32'h0011_2233, "cold_miss");
    do_hit(32'h0000_1004, 32'h0011_2233, "hit");

    // Conflict on index 0
    do_miss(32'h0000_0000, 32'h1111_1111, "conf_a");
    do_miss(32'h0000_0100, 32'h2222_2222, "conf_b");
    do_miss(32'h0000_0000, 32'h3333_3333, "conf_a_again");

    // Flush during LOOKUP suppresses a would-be hit
    start_fetch(32'h0000_1004);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_lookup_valid", {31'd0, inst_valid}, 32'd0);
    check("flush_lookup_ready", {31'd0, ready}, 32'd1);
    check("flush_lookup_noreq", {31'd0, mem_if.icache_in}, 32'd0);

    // Fetch and flush together in IDLE: fetch ignored
    fetch    = 1'b1;
    fetch_pc = 32'h0000_1004;
    flush    = 1'b1;
    tick();
    fetch = 1'b0;
    flush = 1'b0;
    check("fetch_flush_ready", {31'd0, ready}, 32'd1);
    tick();
    check("fetch_flush_valid", {31'd0, inst_valid}, 32'd0);

    // Flush in WAIT, second flush in DROP, fill still written
    start_fetch(32'h0000_2000);
    tick();
    check("drop_req", {31'd0, mem_if.icache_in}, 32'd1);
    mem_if.icache_received = 1'b1;
    tick();
    mem_if.icache_received = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drop_busy", {31'd0, ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drop_second_flush", {31'd0, ready}, 32'd0);
    mem_if.value_load      = 32'hA5A5_A5A5;
    mem_if.icache_task_out = 1'b1;
    tick();
    mem_if.icache_task_out = 1'b0;
    mem_if.value_load      = '0;
    check("drop_no_valid", {31'd0, inst_valid}, 32'd0);
    check("drop_ready", {31'd0, ready}, 32'd1);
    tick();
    check("drop_no_valid_late", {31'd0, inst_valid}, 32'd0);
    do_hit(32'h0000_2000, 32'hA5A5_A5A5, "after_drop_hit");

    // rdy low during REQ, then reset in WAIT
    start_fetch(32'h0000_3000);
    tick();
    check("stall_req", {31'd0, mem_if.icache_in}, 32'd1);
    rdy = 1'b0;
    mem_if.icache_received = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req_held", {31'd0, mem_if.icache_in}, 32'd1);
      check("stall_addr_held", mem_if.icache_address_in, 32'h0000_3000);
      check("stall_ready", {31'd0, ready}, 32'd0);
      check("stall_inst_held", inst, 32'hA5A5_A5A5);
    end
    rdy = 1'b1;
    tick();
    mem_if.icache_received = 1'b0;
    check("stall_req_drop", {31'd0, mem_if.icache_in}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_icache_in", {31'd0, mem_if.icache_in}, 32'd0);
    check("midrst_addr", mem_if.icache_address_in, 32'd0);
    check("midrst_valid", {31'd0, inst_valid}, 32'd0);
    check("midrst_inst", inst, 32'd0);
    check("midrst_pc", inst_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ready", {31'd0, ready}, 32'd1);
    do_miss(32'h0000_1004, 32'h5566_7788, "post_reset_miss");

`ifdef ICACHE_STATS_EN
    check("stats_hit", hit_cnt, 32'd0);
    check("stats_miss", miss_cnt, 32'd1);
`endif

    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter LINES, default 64, number of direct-mapped one-word lines (power of two, 4..256).
REQ-002 SHALL have ports: clk_in  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n_in  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rdy_in  input  1  global ready; low freezes all state and outputs.
REQ-005 SHALL have ports fetch_in (in 1, fetch request), fetch_pc_in (in 32, byte address, bits 1:0 ignored), flush_in (in 1, abandon outstanding fetch).
REQ-006 SHALL have ports ready_out (out 1, can accept fetch), inst_valid_out (out 1, one-cycle pulse), inst_out (out 32, instruction), inst_pc_out (out 32, PC of inst_out).
REQ-007 SHALL have memctrl-side ports icache_in (out 1), icache_address_in (out 32), icache_received (in 1), icache_task_out (in 1), value_load (in 32).

Function
REQ-008 SHALL index with pc[log2(LINES)+1:2] and tag with the remaining upper bits; each line holds valid bit, tag, 32-bit word.
REQ-009 SHALL use FSM states IDLE, LOOKUP, REQ, WAIT, DROP.
REQ-010 IDLE: ready_out=1; fetch_in=1 with flush_in=0 latches PC and goes to LOOKUP.
REQ-011 LOOKUP: on hit, SHALL pulse inst_valid_out with line data and latched PC the next cycle and return to IDLE (hit latency 2 cycles from request).
REQ-012 LOOKUP on miss SHALL go to REQ, driving icache_in=1 and icache_address_in={pc[31:2],2'b00}.
REQ-013 REQ: icache_in and address SHALL stay stable until icache_received=1, then icache_in drops the next cycle and FSM enters WAIT.
REQ-014 WAIT: on icache_task_out=1, SHALL write value_load into the line (valid=1), pulse inst_valid_out with value_load the next cycle, return to IDLE.
REQ-015 value_load SHALL be sampled only when icache_task_out=1; LSU-directed loads are ignored.
REQ-016 ready_out SHALL be 0 in every state except IDLE; fetch_in while not ready is ignored.
REQ-017 flush_in in LOOKUP SHALL suppress the response and return to IDLE.
REQ-018 flush_in in REQ or WAIT SHALL go to DROP, keeping icache_in asserted until received; DROP completes the fill on icache_task_out but SHALL NOT pulse inst_valid_out.
REQ-019 flush_in and fetch_in in the same IDLE cycle: flush wins, fetch ignored.
REQ-020 A second flush while in DROP SHALL have no further effect.
REQ-021 While rdy_in=0, no register (including valid array) SHALL change; memctrl handshakes are held.

Reset
REQ-022 rst_n_in low SHALL immediately force FSM=IDLE, all valid bits=0, icache_in=0, icache_address_in=0, inst_valid_out=0, inst_out=0, inst_pc_out=0; ready_out=1 after release.
REQ-023 Reset mid-miss SHALL abandon the transaction; memctrl is reset by the same event.

Configuration
REQ-024 ICACHE_STATS_EN defined: SHALL add 32-bit outputs hit_cnt_out and miss_cnt_out, counting completed lookups (flushed LOOKUPs excluded), wrapping at 2^32, cleared by reset.
REQ-025 ICACHE_STATS_EN undefined: those ports and counters SHALL be absent; behaviour otherwise identical.

Structure
REQ-026 Shared package SHALL hold ICACHE_LINES default, FSM state encoding, and index/tag width helper constants.
REQ-027 Storage SHALL be one sub-module icache_line_array (read by index, single write port, async valid clear).

Verification
REQ-028 Cold miss: fetch 0x00001004, memctrl returns 0x00112233 -> icache_in with address 0x00001004 held until received, then inst_valid_out with 0x00112233, PC 0x00001004.
REQ-029 Hit: repeat fetch 0x00001004 -> inst_valid_out two cycles after request, no icache_in.
REQ-030 Conflict (LINES=64): fetch 0x00000100 after 0x00000000 -> miss, refill evicts; refetch 0x00000000 misses again.
REQ-031 Flush in WAIT: fetch 0x2000, flush before task_out -> no inst_valid_out; next fetch 0x2000 hits.
REQ-032 LSU interleave: icache_task_out=0 with value_load=0xDEADBEEF during WAIT -> ignored; correct word used later.
REQ-033 rdy_in low 5 cycles during REQ, then reset asserted in WAIT -> outputs frozen, then all outputs 0 and next fetch misses.
